// File: rtl/bt_pipe_pkg.sv
// rtl/bt_pipe_pkg.sv - shared FSM type, endpoint address range and packing helper for the pipe-in endpoint
package bt_pipe_pkg;

   typedef enum logic [1:0] {IDLE, ARMED, BLOCK} state_t;

   localparam logic [7:0] EP_ADDR_MIN = 8'h80;
   localparam logic [7:0] EP_ADDR_MAX = 8'h9F;

   function automatic int pack_ratio(input int out_width);
      return out_width / 32;
   endfunction

endpackage

// File: rtl/bt_sync_fifo.sv
// rtl/bt_sync_fifo.sv - synchronous first-word-fall-through FIFO with registered output and entry count
module bt_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   output logic [WIDTH-1:0]         dout,
   output logic                     dout_valid,
   input  logic                     dout_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    mem_count;
   logic             wr_en;
   logic             pop;
   logic             load;

   // level counts the output register too, so total capacity is exactly DEPTH
   assign full  = (level == LW'(DEPTH));
   assign wr_en = push & ~full;
   assign pop   = dout_valid & dout_ready;
   assign load  = (mem_count != '0) & (~dout_valid | pop);

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         mem_count  <= '0;
         level      <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (load) begin
            dout       <= mem[rd_ptr];
            dout_valid <= 1'b1;
            rd_ptr     <= rd_ptr + AW'(1);
         end else if (pop) begin
            dout_valid <= 1'b0;
         end
         mem_count <= mem_count + LW'(wr_en) - LW'(load);
         level     <= level + LW'(wr_en) - LW'(pop);
      end
   end

endmodule

// File: rtl/bt_pipe_in_buffered.sv
// rtl/bt_pipe_in_buffered.sv - block-throttled pipe-in endpoint with FIFO and stream output
// Optional status ports (fifo_level, block_count) enabled by BT_PIPE_IN_STATUS_EN.
module bt_pipe_in_buffered
   import bt_pipe_pkg::*;
#(
   parameter logic [7:0] EP_ADDR     = 8'h80,
   parameter int         OUT_WIDTH   = 32,
   parameter int         FIFO_DEPTH  = 512,
   parameter int         BLOCK_WORDS = 256
) (
   input  logic                  ti_clk,
   input  logic                  ti_reset,
   input  logic [7:0]            ti_addr,
   input  logic                  ti_write,
   input  logic                  ti_blockstrobe,
   input  logic [31:0]           ti_datain,
   output logic                  ep_ready,
   output logic [OUT_WIDTH-1:0]  dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic                  err_overflow,
   output logic                  err_protocol
`ifdef BT_PIPE_IN_STATUS_EN
   ,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic [15:0]                 block_count
`endif
);

   localparam int RATIO = pack_ratio(OUT_WIDTH);
   localparam int LW    = $clog2(FIFO_DEPTH) + 1;
   localparam int WCW   = $clog2(BLOCK_WORDS + 1);

   if (EP_ADDR < EP_ADDR_MIN || EP_ADDR > EP_ADDR_MAX) begin : g_bad_addr
      $error("bt_pipe_in_buffered: EP_ADDR outside 0x80-0x9F");
   end
   if (OUT_WIDTH != 32 && OUT_WIDTH != 64) begin : g_bad_width
      $error("bt_pipe_in_buffered: OUT_WIDTH must be 32 or 64");
   end
   if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("bt_pipe_in_buffered: FIFO_DEPTH must be a power of two >= 4");
   end
   if (BLOCK_WORDS < 1 || BLOCK_WORDS > FIFO_DEPTH * RATIO || (RATIO == 2 && BLOCK_WORDS % 2 != 0)) begin : g_bad_block
      $error("bt_pipe_in_buffered: illegal BLOCK_WORDS");
   end

   state_t                 state, state_n;
   logic [WCW-1:0]         word_count, wc_n;
   logic                   hit, accept, proto_hit;
   logic                   push, pack_half, fifo_full, ep_ready_r;
   logic [OUT_WIDTH-1:0]   push_data;
   logic [LW-1:0]          level;
   int                     remaining, free;

   assign hit      = (ti_addr == EP_ADDR);
   assign ep_ready = ep_ready_r & hit;

   // Space still owed to the block in progress is reserved before offering another block
   always_comb begin
      remaining = (state == IDLE) ? 0 : BLOCK_WORDS - int'(word_count);
      free      = (FIFO_DEPTH - int'(level)) * RATIO - int'(pack_half) - remaining;
   end

   always_comb begin
      state_n   = state;
      wc_n      = word_count;
      accept    = 1'b0;
      proto_hit = 1'b0;
      if (hit) begin
         if (ti_blockstrobe) begin
            proto_hit = (state != IDLE) | ti_write;
            state_n   = ARMED;
            wc_n      = '0;
         end else if (ti_write) begin
            if (state == IDLE) begin
               proto_hit = 1'b1;
            end else begin
               accept  = 1'b1;
               wc_n    = word_count + WCW'(1);
               state_n = (wc_n == WCW'(BLOCK_WORDS)) ? IDLE : BLOCK;
            end
         end
      end
   end

   always_ff @(posedge ti_clk) begin
      if (ti_reset) begin
         state        <= IDLE;
         word_count   <= '0;
         err_overflow <= 1'b0;
         err_protocol <= 1'b0;
         ep_ready_r   <= 1'b0;
      end else begin
         state        <= state_n;
         word_count   <= wc_n;
         err_overflow <= err_overflow | (push & fifo_full);
         err_protocol <= err_protocol | proto_hit;
         ep_ready_r   <= (free >= BLOCK_WORDS);
      end
   end

   if (RATIO == 2) begin : g_pack
      logic [31:0] pack_lo;
      always_ff @(posedge ti_clk) begin
         if (ti_reset) begin
            pack_half <= 1'b0;
            pack_lo   <= '0;
         end else if (accept) begin
            pack_half <= ~pack_half;
            if (!pack_half) pack_lo <= ti_datain;
         end
      end
      assign push      = accept & pack_half;
      assign push_data = {ti_datain, pack_lo};
   end else begin : g_direct
      assign pack_half = 1'b0;
      assign push      = accept;
      assign push_data = ti_datain;
   end

   bt_sync_fifo #(
      .WIDTH (OUT_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (ti_clk),
      .reset      (ti_reset),
      .push       (push),
      .push_data  (push_data),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .level      (level),
      .full       (fifo_full)
   );

`ifdef BT_PIPE_IN_STATUS_EN
   assign fifo_level = level;

   always_ff @(posedge ti_clk) begin
      if (ti_reset) block_count <= '0;
      else if (accept && wc_n == WCW'(BLOCK_WORDS)) block_count <= block_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_bt_pipe_in_buffered.sv
// tb/tb_bt_pipe_in_buffered.sv - table, directed and random checks of a 32-bit and a 64-bit endpoint on a shared host bus
module tb_bt_pipe_in_buffered;

   localparam logic [7:0] EP = 8'h85;
   localparam int BW = 4;

   logic        clk = 1'b0;
   logic        reset, t_write, t_strobe, dready;
   logic [7:0]  addr;
   logic [31:0] din;
   logic        ep_a, ep_b, valid_a, valid_b, ovf_a, ovf_b, proto_a, proto_b;
   logic [31:0] dout_a;
   logic [63:0] dout_b;
`ifdef BT_PIPE_IN_STATUS_EN
   logic [3:0]  lvl_a;
   logic [2:0]  lvl_b;
   logic [15:0] bc_a, bc_b;
`endif

   always #5 clk = ~clk;

   bt_pipe_in_buffered #(.EP_ADDR(EP), .OUT_WIDTH(32), .FIFO_DEPTH(8), .BLOCK_WORDS(BW)) dut_a (
      .ti_clk(clk), .ti_reset(reset), .ti_addr(addr), .ti_write(t_write),
      .ti_blockstrobe(t_strobe), .ti_datain(din), .ep_ready(ep_a), .dout(dout_a),
      .dout_valid(valid_a), .dout_ready(dready), .err_overflow(ovf_a), .err_protocol(proto_a)
`ifdef BT_PIPE_IN_STATUS_EN
      , .fifo_level(lvl_a), .block_count(bc_a)
`endif
   );

   bt_pipe_in_buffered #(.EP_ADDR(EP), .OUT_WIDTH(64), .FIFO_DEPTH(4), .BLOCK_WORDS(BW)) dut_b (
      .ti_clk(clk), .ti_reset(reset), .ti_addr(addr), .ti_write(t_write),
      .ti_blockstrobe(t_strobe), .ti_datain(din), .ep_ready(ep_b), .dout(dout_b),
      .dout_valid(valid_b), .dout_ready(dready), .err_overflow(ovf_b), .err_protocol(proto_b)
`ifdef BT_PIPE_IN_STATUS_EN
      , .fifo_level(lvl_b), .block_count(bc_b)
`endif
   );

   logic        dv [2];
   logic [63:0] dd [2];
   logic        epr [2];
   logic        ovf [2];
   logic        prt [2];
   assign dv[0] = valid_a;  assign dv[1] = valid_b;
   assign dd[0] = {32'b0, dout_a};  assign dd[1] = dout_b;
   assign epr[0] = ep_a;    assign epr[1] = ep_b;
   assign ovf[0] = ovf_a;   assign ovf[1] = ovf_b;
   assign prt[0] = proto_a; assign prt[1] = proto_b;

   int tests = 0;
   int fails = 0;

   // transaction-level reference: block bookkeeping, packer half, expected word queues, entry counts
   bit          m_active [2];
   bit          m_half [2];
   bit          m_ovf [2];
   bit          m_proto [2];
   bit          m_pred [2];
   int          m_wc [2];
   int          m_level [2];
   int          pop_cnt [2];
   logic [31:0] m_lo [2];
   logic [63:0] qa [$];
   logic [63:0] qb [$];
   bit          rand_ready = 1'b0;

   function automatic int depth_of(input int i);
      return (i == 0) ? 8 : 4;
   endfunction

   function automatic int ratio_of(input int i);
      return (i == 0) ? 1 : 2;
   endfunction

   function automatic int q_size(input int i);
      return (i == 0) ? qa.size() : qb.size();
   endfunction

   task automatic q_push(input int i, input logic [63:0] w);
      if (i == 0) qa.push_back(w);
      else        qb.push_back(w);
   endtask

   task automatic q_pop(input int i, output logic [63:0] w);
      if (i == 0) w = qa.pop_front();
      else        w = qb.pop_front();
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_clear(input int i);
      m_active[i] = 1'b0; m_half[i] = 1'b0; m_ovf[i] = 1'b0; m_proto[i] = 1'b0;
      m_wc[i] = 0; m_level[i] = 0; m_lo[i] = '0;
      if (i == 0) qa.delete();
      else        qb.delete();
   endtask

   task automatic tick();
      bit          hit, popped, pushed, full;
      int          free;
      logic [63:0] w, e;
      if (rand_ready) dready = ($urandom_range(3) != 0);
      hit = (addr == EP);
      for (int i = 0; i < 2; i++) begin
         free = (depth_of(i) - m_level[i]) * ratio_of(i) - int'(m_half[i])
                - (m_active[i] ? BW - m_wc[i] : 0);
         m_pred[i] = reset ? 1'b0 : (free >= BW);
         if (reset) begin
            model_clear(i);
            continue;
         end
         popped = dv[i] && dready;
         full   = (m_level[i] == depth_of(i));
         pushed = 1'b0;
         w      = '0;
         if (popped) begin
            pop_cnt[i]++;
            if (q_size(i) == 0) check($sformatf("unexpected_valid[%0d]", i), 64'd1, 64'd0);
            else begin
               q_pop(i, e);
               check($sformatf("dout[%0d]", i), dd[i], e);
            end
         end
         if (hit && t_strobe) begin
            if (m_active[i] || t_write) m_proto[i] = 1'b1;
            m_active[i] = 1'b1;
            m_wc[i] = 0;
         end else if (hit && t_write) begin
            if (!m_active[i]) m_proto[i] = 1'b1;
            else begin
               m_wc[i]++;
               if (m_wc[i] == BW) m_active[i] = 1'b0;
               if (ratio_of(i) == 1) begin
                  w = {32'b0, din}; pushed = 1'b1;
               end else if (m_half[i]) begin
                  w = {din, m_lo[i]}; m_half[i] = 1'b0; pushed = 1'b1;
               end else begin
                  m_lo[i] = din; m_half[i] = 1'b1;
               end
            end
         end
         if (pushed) begin
            if (full) begin
               m_ovf[i] = 1'b1;
               pushed = 1'b0;
            end else q_push(i, w);
         end
         m_level[i] = m_level[i] - int'(popped) + int'(pushed);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("ep_ready[%0d]", i), 64'(epr[i]), 64'(m_pred[i] && addr == EP));
         check($sformatf("err_overflow[%0d]", i), 64'(ovf[i]), 64'(m_ovf[i]));
         check($sformatf("err_protocol[%0d]", i), 64'(prt[i]), 64'(m_proto[i]));
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; t_write = 1'b0; t_strobe = 1'b0; addr = EP;
      tick();
      reset = 1'b0;
   endtask

   task automatic idle(input int n);
      t_write = 1'b0; t_strobe = 1'b0;
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic wr(input logic [31:0] d);
      t_write = 1'b1; t_strobe = 1'b0; din = d;
      tick();
      t_write = 1'b0;
   endtask

   task automatic strb();
      t_strobe = 1'b1; t_write = 1'b0;
      tick();
      t_strobe = 1'b0;
   endtask

   typedef struct {
      bit          strobe;
      bit          write;
      logic [31:0] data;
      bit          v_a;
      logic [31:0] d_a;
      bit          v_b;
      logic [63:0] d_b;
   } vec_t;

   vec_t tbl [7];

   initial begin
      tbl[0] = '{1, 0, 32'h0, 0, 32'h0, 0, 64'h0};
      tbl[1] = '{0, 1, 32'hA, 0, 32'h0, 0, 64'h0};
      tbl[2] = '{0, 1, 32'hB, 1, 32'hA, 0, 64'h0};
      tbl[3] = '{0, 1, 32'hC, 1, 32'hB, 1, 64'h0000000B_0000000A};
      tbl[4] = '{0, 1, 32'hD, 1, 32'hC, 0, 64'h0};
      tbl[5] = '{0, 0, 32'h0, 1, 32'hD, 1, 64'h0000000D_0000000C};
      tbl[6] = '{0, 0, 32'h0, 0, 32'h0, 0, 64'h0};

      pop_cnt[0] = 0; pop_cnt[1] = 0;
      din = '0; dready = 1'b1;
      do_reset();
      check("reset_valid_a", 64'(valid_a), 64'd0);
      check("reset_valid_b", 64'(valid_b), 64'd0);
      check("reset_dout_b", dout_b, 64'd0);
      idle(1);

      // basic block through both widths, exact output timing
      for (int r = 0; r < 7; r++) begin
         t_strobe = tbl[r].strobe; t_write = tbl[r].write; din = tbl[r].data;
         tick();
         check($sformatf("tbl%0d_valid_a", r), 64'(valid_a), 64'(tbl[r].v_a));
         check($sformatf("tbl%0d_valid_b", r), 64'(valid_b), 64'(tbl[r].v_b));
         if (tbl[r].v_a) check($sformatf("tbl%0d_dout_a", r), 64'(dout_a), 64'(tbl[r].d_a));
         if (tbl[r].v_b) check($sformatf("tbl%0d_dout_b", r), dout_b, tbl[r].d_b);
      end
      t_write = 1'b0; t_strobe = 1'b0;

      // a single odd word stays in the packer
      do_reset();
      strb(); wr(32'h1234_5678); idle(4);
      check("odd_word_valid_b", 64'(valid_b), 64'd0);
      check("odd_word_valid_a", 64'(valid_a), 64'd0);

      // ep_ready throttling with a stalled consumer
      dready = 1'b0;
      do_reset(); idle(1);
      check("bp_ready_start", 64'(ep_a), 64'd1);
      strb(); for (int k = 0; k < BW; k++) wr(32'h100 + k);
      strb(); idle(1);
      check("bp_ready_drop", 64'(ep_a), 64'd0);
      for (int k = 0; k < BW; k++) wr(32'h200 + k);
      dready = 1'b1; idle(4); dready = 1'b0; idle(1);
      check("bp_ready_back", 64'(ep_a), 64'd1);
      dready = 1'b1; idle(10);

      // protocol errors: write outside a block, strobe mid-block
      do_reset();
      wr(32'hDEAD); idle(3);
      check("proto_nostrobe", 64'(proto_a), 64'd1);
      check("proto_nostrobe_valid", 64'(valid_a), 64'd0);
      do_reset();
      strb(); wr(32'h11); wr(32'h22);
      check("proto_before_restrobe", 64'(proto_b), 64'd0);
      strb();
      check("proto_restrobe", 64'(proto_b), 64'd1);
      for (int k = 0; k < BW; k++) wr(32'h30 + k);
      idle(8);

      // overflow when ep_ready is ignored
      dready = 1'b0;
      do_reset();
      for (int b = 0; b < 3; b++) begin
         strb();
         for (int k = 0; k < ((b == 2) ? 1 : BW); k++) wr(32'h500 + 32'(b * 8 + k));
      end
      check("ovf_a_set", 64'(ovf_a), 64'd1);
      check("ovf_b_clear", 64'(ovf_b), 64'd0);
      pop_cnt[0] = 0; pop_cnt[1] = 0;
      dready = 1'b1; idle(12);
      check("ovf_drain_a", 64'(pop_cnt[0]), 64'd8);
      check("ovf_drain_b", 64'(pop_cnt[1]), 64'd4);

      // reset in the middle of a block
      do_reset();
      strb(); wr(32'h71); wr(32'h72);
      reset = 1'b1; tick(); reset = 1'b0;
      check("midrst_valid_a", 64'(valid_a), 64'd0);
      check("midrst_proto_a", 64'(proto_a), 64'd0);
      idle(1);
      check("midrst_ready_a", 64'(ep_a), 64'd1);
      check("midrst_ready_b", 64'(ep_b), 64'd1);
      strb(); for (int k = 0; k < BW; k++) wr(32'h80 + k);
      idle(6);

      // randomized well-behaved host with address misses and a random consumer
      do_reset();
      rand_ready = 1'b1;
      for (int blk = 0; blk < 60; blk++) begin
         for (int k = 0; k < 64 && !(ep_a && ep_b); k++) idle(1);
         check("wait_ep_ready", 64'(ep_a && ep_b), 64'd1);
         strb();
         for (int k = 0; k < BW; k++) begin
            while ($urandom_range(3) == 0) begin
               addr = 8'h80 + 8'($urandom_range(31));
               if (addr == EP) addr = 8'h9F;
               t_write = 1'($urandom_range(1)); din = $urandom;
               tick();
               addr = EP; t_write = 1'b0;
            end
            wr($urandom);
         end
      end
      rand_ready = 1'b0;
      dready = 1'b1; idle(20);
      check("drain_empty_a", 64'(q_size(0)), 64'd0);
      check("drain_empty_b", 64'(q_size(1)), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
